// File: rtl/add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nor_full_adder.sv
// 1-bit full adder built from nine Pierce (NOR) gates.
module nor_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic n1, n2, n3, n4, n5, n6, n7;

    // n4 = xnor(a, b); s = xnor(n4, cin) = a ^ b ^ cin
    pierce u_g1 (.a(a),   .b(b),   .y(n1));
    pierce u_g2 (.a(a),   .b(n1),  .y(n2));
    pierce u_g3 (.a(b),   .b(n1),  .y(n3));
    pierce u_g4 (.a(n2),  .b(n3),  .y(n4));
    pierce u_g5 (.a(n4),  .b(cin), .y(n5));
    pierce u_g6 (.a(n4),  .b(n5),  .y(n6));
    pierce u_g7 (.a(cin), .b(n5),  .y(n7));
    pierce u_g8 (.a(n6),  .b(n7),  .y(s));
    // cout = (a | b) & (xnor(a, b) | cin)
    pierce u_g9 (.a(n1),  .b(n5),  .y(cout));

endmodule

// File: rtl/pierce.sv
// Two-input NOR (Pierce arrow) primitive; the only gate used by the serial adder datapath.
module pierce (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a | b);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: LSB-first through one shared NOR full adder, IDLE/RUN/DONE control.
module serial_add_ctrl
    import add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_sh_q, res_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               fa_s, fa_co;
    logic [WIDTH-1:0]   res_next;

    nor_full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    assign res_next = {fa_s, res_sh_q[WIDTH-1:1]};

    // Next-state and datapath updates; result registers change only on a completed add
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    res_sh_d = '0;
                    carry_d  = cin;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                    res_sh_d = res_next;
                    carry_d  = fa_co;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        sum_d   = res_next;
                        cout_d  = fa_co;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d == RUN);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         abort;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks;
    int errors;
    logic [W-1:0] last_sum;
    logic         last_cout;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vc;
        logic [W-1:0] es;
        logic         eco;
    } vec_t;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .abort (abort),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One complete addition; optional ignored start mid-run and on the DONE cycle.
    task automatic do_add(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                          input logic [W-1:0] es, input logic eco,
                          input int restart_at, input bit poke_done);
        int cyc;
        start = 1'b1;
        a = va;
        b = vb;
        cin = vc;
        @(posedge clk); #1;
        start = 1'b0;
        a = ~va;
        b = ~vb;
        cin = ~vc;
        chk("busy_in_run", 32'(busy), 32'd1);
        chk("ready_in_run", 32'(ready), 32'd0);
        cyc = 0;
        while (!done && cyc < 40) begin
            if (cyc == restart_at) begin
                start = 1'b1;
                a = 8'h3C;
                b = 8'h11;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("latency", 32'(cyc), 32'(W));
        chk("done_seen", 32'(done), 32'd1);
        chk("sum", 32'(sum), 32'(es));
        chk("cout", 32'(cout), 32'(eco));
        if (poke_done) begin
            start = 1'b1;
            a = 8'h77;
            b = 8'h01;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_single", 32'(done), 32'd0);
        chk("ready_after", 32'(ready), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        last_sum  = es;
        last_cout = eco;
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        vec_t vecs[10];
        int   nd;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   rexp;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[7] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};
        vecs[8] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
        vecs[9] = '{8'h01, 8'h01, 1'b1, 8'h03, 1'b0};

        checks = 0;
        errors = 0;
        last_sum = '0;
        last_cout = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);

        // First start goes in on the first rising edge after release
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            do_add(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].es, vecs[i].eco,
                   (i == 3) ? 3 : -1, (i == 2));
        end

        // Start beats abort in IDLE, then abort at RUN cycle 4
        start = 1'b1;
        abort = 1'b1;
        a = 8'h12;
        b = 8'h34;
        cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_beats_abort", 32'(busy), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sum_kept", 32'(sum), 32'(last_sum));
        chk("abort_cout_kept", 32'(cout), 32'(last_cout));
        count_dones(12, nd);
        chk("abort_no_done", 32'(nd), 32'd0);
        do_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, -1, 1'b0);

        // Reset at RUN cycle 5
        start = 1'b1;
        a = 8'h33;
        b = 8'h44;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        last_sum = '0;
        last_cout = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(12, nd);
        chk("midrst_no_done", 32'(nd), 32'd0);
        chk("midrst_sum_hold", 32'(sum), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_add(8'h33, 8'h44, 1'b0, 8'h77, 1'b0, -1, 1'b0);

        // Random back-to-back operands
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rexp = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            do_add(ra, rb, rc, rexp[W-1:0], rexp[W], -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
